// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Game Boy interrupt controller. Captures rising edges on the five
//            peripheral interrupt lines into IF (0xFF0F), holds the enable
//            mask IE (0xFFFF), picks the highest-priority pending and enabled
//            source, and runs a request/acknowledge dispatch handshake with
//            the CPU core. The master enable (IME) lives in the CPU.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1  CPU clock
//   reset      in   1  asynchronous, active-high reset
//   irq_src    in   5  VBlank, LCD STAT, timer, serial, joypad (rising edge)
//   cpu_sel_if in   1  CPU selects IF
//   cpu_sel_ie in   1  CPU selects IE
//   cpu_wr     in   1  write strobe, qualified by a select
//   cpu_di     in   8  write data
//   cpu_do     out  8  read data (0xFF when nothing selected)
//   irq_req    out  1  dispatch request to the CPU
//   irq_vec    out  8  vector of the latched source, valid while irq_req=1
//   irq_ack    in   1  single-cycle dispatch accept from the CPU
//   wake       out  1  any pending and enabled source (HALT/STOP exit)
// ============================================================================
module irq_ctrl #(
    parameter logic [7:0] VEC_BASE   = 8'h40,
    parameter logic [7:0] VEC_STRIDE = 8'h08
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] irq_src,
    input  logic       cpu_sel_if,
    input  logic       cpu_sel_ie,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    output logic       irq_req,
    output logic [7:0] irq_vec,
    input  logic       irq_ack,
    output logic       wake
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] if_q, if_d;
    logic [7:0] ie_q, ie_d;
    logic [4:0] src_prev_q;
    logic [2:0] idx_q, idx_d;
    logic [7:0] vec_q, vec_d;
    logic       wake_q, wake_d;

    logic [4:0] set_mask;
    logic [4:0] active;
    logic [4:0] active_d;
    logic [4:0] idx_mask;
    logic [2:0] win_idx;
    logic       ack_take;

    always_comb begin
        set_mask = irq_src & ~src_prev_q;
        active   = if_q & ie_q[4:0];
        idx_mask = 5'b00001 << idx_q;
        ack_take = (state_q == ST_REQ) && irq_ack;

        // Lowest set bit wins: scan from lowest priority upward so the
        // last assignment is the highest-priority pending source.
        win_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (active[i]) begin
                win_idx = 3'(i);
            end
        end

        ie_d = ie_q;
        if (cpu_sel_ie && cpu_wr) begin
            ie_d = cpu_di;
        end

        // Write, then ack clear, then edge set: a source edge always survives
        // a coincident clearing write or acknowledge.
        if_d = if_q;
        if (cpu_sel_if && cpu_wr) begin
            if_d = cpu_di[4:0];
        end
        if (ack_take) begin
            if_d = if_d & ~idx_mask;
        end
        if_d = if_d | set_mask;

        active_d = if_d & ie_d[4:0];
        wake_d   = |active_d;

        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (|active) begin
                    state_d = ST_REQ;
                    idx_d   = win_idx;
                    vec_d   = VEC_BASE + ({5'b00000, win_idx} * VEC_STRIDE);
                end
            end
            ST_REQ: begin
                // Vector stays frozen here; a cancelled source drops the
                // request and re-arbitration happens from IDLE.
                if (irq_ack) begin
                    state_d = ST_GAP;
                end else if ((active_d & idx_mask) == 5'b00000) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            if_q       <= 5'b00000;
            ie_q       <= 8'h00;
            src_prev_q <= 5'b00000;
            idx_q      <= 3'd0;
            vec_q      <= 8'h00;
            wake_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_q       <= if_d;
            ie_q       <= ie_d;
            src_prev_q <= irq_src;
            idx_q      <= idx_d;
            vec_q      <= vec_d;
            wake_q     <= wake_d;
        end
    end

    always_comb begin
        if (cpu_sel_if) begin
            cpu_do = {3'b111, if_q};
        end else if (cpu_sel_ie) begin
            cpu_do = ie_q;
        end else begin
            cpu_do = 8'hFF;
        end
    end

    assign irq_req = (state_q == ST_REQ);
    assign irq_vec = vec_q;
    assign wake    = wake_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Directed self-checking bench for irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] irq_src;
    logic       cpu_sel_if;
    logic       cpu_sel_ie;
    logic       cpu_wr;
    logic [7:0] cpu_di;
    logic [7:0] cpu_do;
    logic       irq_req;
    logic [7:0] irq_vec;
    logic       irq_ack;
    logic       wake;

    int vectors;
    int miscompares;

    irq_ctrl #(
        .VEC_BASE  (8'h40),
        .VEC_STRIDE(8'h08)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .cpu_sel_if(cpu_sel_if),
        .cpu_sel_ie(cpu_sel_ie),
        .cpu_wr    (cpu_wr),
        .cpu_di    (cpu_di),
        .cpu_do    (cpu_do),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .wake      (wake)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 2 time units past the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        irq_src = 5'h00; cpu_sel_if = 0; cpu_sel_ie = 0; cpu_wr = 0;
        cpu_di = 8'h00; irq_ack = 0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic write_reg(input logic is_if, input logic [7:0] data);
        cpu_sel_if = is_if; cpu_sel_ie = ~is_if; cpu_wr = 1'b1; cpu_di = data;
        cyc();
        cpu_sel_if = 0; cpu_sel_ie = 0; cpu_wr = 0; cpu_di = 8'h00;
    endtask

    // Combinational read of IF (is_if=1) or IE.
    task automatic read_reg(input logic is_if, output logic [7:0] data);
        cpu_sel_if = is_if; cpu_sel_ie = ~is_if;
        #1;
        data = cpu_do;
        cpu_sel_if = 0; cpu_sel_ie = 0;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        do_reset();
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", irq_req); end
        vectors++; if (irq_vec !== 8'h00) begin miscompares++; $display("FAIL reset_vec: got %h want 00", irq_vec); end
        vectors++; if (wake !== 1'b0) begin miscompares++; $display("FAIL reset_wake: got %b want 0", wake); end
        read_reg(1'b1, rd);
        vectors++; if (rd !== 8'hE0) begin miscompares++; $display("FAIL reset_if: got %h want e0", rd); end
        read_reg(1'b0, rd);
        vectors++; if (rd !== 8'h00) begin miscompares++; $display("FAIL reset_ie: got %h want 00", rd); end
        #1;
        vectors++; if (cpu_do !== 8'hFF) begin miscompares++; $display("FAIL reset_nosel: got %h want ff", cpu_do); end
    endtask

    task automatic test_timer_pulse();
        logic [7:0] rd;
        do_reset();
        write_reg(1'b0, 8'h04);
        irq_src = 5'h04; cyc(); irq_src = 5'h00;
        read_reg(1'b1, rd);
        vectors++; if (rd !== 8'hE4) begin miscompares++; $display("FAIL timer_if: got %h want e4", rd); end
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL timer_req_lat: got %b want 0", irq_req); end
        vectors++; if (wake !== 1'b1) begin miscompares++; $display("FAIL timer_wake: got %b want 1", wake); end
        cyc();
        vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL timer_req: got %b want 1", irq_req); end
        vectors++; if (irq_vec !== 8'h50) begin miscompares++; $display("FAIL timer_vec: got %h want 50", irq_vec); end
        irq_ack = 1; cyc(); irq_ack = 0;
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL timer_gap: got %b want 0", irq_req); end
        cyc();
        // Held level: one set, then nothing more after it is acked.
        irq_src = 5'h04; cyc(); cyc();
        vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL level_req: got %b want 1", irq_req); end
        irq_ack = 1; cyc(); irq_ack = 0;
        cyc(); cyc(); cyc();
        read_reg(1'b1, rd);
        vectors++; if (rd !== 8'hE0) begin miscompares++; $display("FAIL level_once_if: got %h want e0", rd); end
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL level_once_req: got %b want 0", irq_req); end
        irq_src = 5'h00;
    endtask

    task automatic test_priority();
        logic [7:0] rd;
        do_reset();
        write_reg(1'b0, 8'h1F);
        irq_src = 5'h11; cyc(); irq_src = 5'h00;
        cyc();
        vectors++; if (irq_vec !== 8'h40 || irq_req !== 1'b1) begin miscompares++; $display("FAIL prio_first: got req=%b vec=%h want req=1 vec=40", irq_req, irq_vec); end
        irq_ack = 1; cyc(); irq_ack = 0;
        read_reg(1'b1, rd);
        vectors++; if (rd !== 8'hF0) begin miscompares++; $display("FAIL prio_if_after_ack: got %h want f0", rd); end
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL prio_gap: got %b want 0", irq_req); end
        cyc();
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL prio_idle: got %b want 0", irq_req); end
        cyc();
        vectors++; if (irq_vec !== 8'h60 || irq_req !== 1'b1) begin miscompares++; $display("FAIL prio_second: got req=%b vec=%h want req=1 vec=60", irq_req, irq_vec); end
    endtask

    task automatic test_hold_vector();
        logic [7:0] rd;
        do_reset();
        write_reg(1'b0, 8'h1F);
        irq_src = 5'h08; cyc(); irq_src = 5'h00;
        cyc();
        vectors++; if (irq_vec !== 8'h58 || irq_req !== 1'b1) begin miscompares++; $display("FAIL hold_first: got req=%b vec=%h want req=1 vec=58", irq_req, irq_vec); end
        irq_src = 5'h01; cyc(); irq_src = 5'h00;
        read_reg(1'b1, rd);
        vectors++; if (rd !== 8'hE9) begin miscompares++; $display("FAIL hold_if: got %h want e9", rd); end
        cyc();
        vectors++; if (irq_vec !== 8'h58 || irq_req !== 1'b1) begin miscompares++; $display("FAIL hold_stable: got req=%b vec=%h want req=1 vec=58", irq_req, irq_vec); end
        irq_ack = 1; cyc(); irq_ack = 0;
        cyc(); cyc();
        vectors++; if (irq_vec !== 8'h40 || irq_req !== 1'b1) begin miscompares++; $display("FAIL hold_next: got req=%b vec=%h want req=1 vec=40", irq_req, irq_vec); end
    endtask

    task automatic test_cancel();
        logic [7:0] rd;
        do_reset();
        write_reg(1'b0, 8'h04);
        irq_src = 5'h04; cyc(); irq_src = 5'h00;
        cyc();
        vectors++; if (irq_vec !== 8'h50 || irq_req !== 1'b1) begin miscompares++; $display("FAIL cancel_pre: got req=%b vec=%h want req=1 vec=50", irq_req, irq_vec); end
        write_reg(1'b0, 8'h00);
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL cancel_req: got %b want 0", irq_req); end
        vectors++; if (wake !== 1'b0) begin miscompares++; $display("FAIL cancel_wake: got %b want 0", wake); end
        read_reg(1'b1, rd);
        vectors++; if (rd !== 8'hE4) begin miscompares++; $display("FAIL cancel_if: got %h want e4", rd); end
        cyc();
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL cancel_stay: got %b want 0", irq_req); end
        write_reg(1'b0, 8'h04);
        cyc();
        vectors++; if (irq_vec !== 8'h50 || irq_req !== 1'b1) begin miscompares++; $display("FAIL cancel_reissue: got req=%b vec=%h want req=1 vec=50", irq_req, irq_vec); end
    endtask

    task automatic test_collision();
        logic [7:0] rd;
        do_reset();
        // IE=0 keeps the dispatcher idle while IF collisions are probed.
        irq_src = 5'h01; cyc(); irq_src = 5'h00;
        irq_ack = 1; cyc(); irq_ack = 0;
        read_reg(1'b1, rd);
        vectors++; if (rd !== 8'hE1) begin miscompares++; $display("FAIL idle_ack_if: got %h want e1", rd); end
        irq_src = 5'h08;
        write_reg(1'b1, 8'h00);
        irq_src = 5'h00;
        read_reg(1'b1, rd);
        vectors++; if (rd !== 8'hE8) begin miscompares++; $display("FAIL wr_vs_edge_if: got %h want e8", rd); end
        write_reg(1'b0, 8'h04);
        irq_src = 5'h04; cyc(); irq_src = 5'h00;
        cyc();
        vectors++; if (irq_vec !== 8'h50 || irq_req !== 1'b1) begin miscompares++; $display("FAIL coll_req: got req=%b vec=%h want req=1 vec=50", irq_req, irq_vec); end
        irq_ack = 1; irq_src = 5'h04; cyc(); irq_ack = 0; irq_src = 5'h00;
        read_reg(1'b1, rd);
        vectors++; if (rd !== 8'hEC) begin miscompares++; $display("FAIL ack_vs_edge_if: got %h want ec", rd); end
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL ack_vs_edge_gap: got %b want 0", irq_req); end
        cyc(); cyc();
        vectors++; if (irq_vec !== 8'h50 || irq_req !== 1'b1) begin miscompares++; $display("FAIL ack_vs_edge_redo: got req=%b vec=%h want req=1 vec=50", irq_req, irq_vec); end
    endtask

    task automatic test_async_reset();
        logic [7:0] rd;
        do_reset();
        write_reg(1'b0, 8'h04);
        irq_src = 5'h04; cyc(); irq_src = 5'h00;
        cyc();
        vectors++; if (irq_req !== 1'b1 || wake !== 1'b1) begin miscompares++; $display("FAIL areset_pre: got req=%b wake=%b want 1/1", irq_req, wake); end
        // Mid-cycle, well away from any rising edge.
        #1 reset = 1'b1;
        #1;
        vectors++; if (irq_req !== 1'b0 || irq_vec !== 8'h00 || wake !== 1'b0) begin miscompares++; $display("FAIL areset_out: got req=%b vec=%h wake=%b want 0/00/0", irq_req, irq_vec, wake); end
        read_reg(1'b1, rd);
        vectors++; if (rd !== 8'hE0) begin miscompares++; $display("FAIL areset_if: got %h want e0", rd); end
        read_reg(1'b0, rd);
        vectors++; if (rd !== 8'h00) begin miscompares++; $display("FAIL areset_ie: got %h want 00", rd); end
        vectors++; if (cpu_do !== 8'hFF) begin miscompares++; $display("FAIL areset_nosel: got %h want ff", cpu_do); end
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        irq_src = 5'h00; cpu_sel_if = 0; cpu_sel_ie = 0; cpu_wr = 0;
        cpu_di = 8'h00; irq_ack = 0;
        test_reset();
        test_timer_pulse();
        test_priority();
        test_hold_vector();
        test_cancel();
        test_collision();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
